crc_frame_rx: RTL and testbench
===============================

Name: crc_frame_rx

Overview:
- Upstream framing stage between the UART receiver and the payload consumer.
- Accepts the raw UART byte stream and delimits frames as SOF, LEN, payload, CRC_H, CRC_L.
- Computes CRC-16 over the payload on the fly, forwards payload bytes downstream and issues one frame verdict per frame: good or error code.
- Keeps saturating good/bad frame counters for status readback.

Parameters:
- SOF_BYTE, 8'h7E, start-of-frame marker.
- MAX_LEN, 64, maximum payload length in bytes (1..255).
- CRC_POLY, 16'h1021, CRC-16 generator polynomial.
- CRC_INIT, 16'h0000, CRC register value at the start of each frame.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- pl_data  out  8  forwarded payload byte.
- pl_valid  out  1  one-cycle strobe per payload byte.
- pl_first  out  1  qualifies pl_valid: first payload byte of the frame.
- pl_last  out  1  qualifies pl_valid: last payload byte of the frame.
- frame_done  out  1  one-cycle verdict strobe.
- frame_ok  out  1  valid with frame_done: 1 means the CRC matched.
- err_code  out  2  valid with frame_done: 0 none, 1 CRC mismatch, 2 bad length, 3 timeout.
- good_cnt  out  16  count of frames with frame_ok=1; saturates at 16'hFFFF.
- bad_cnt  out  16  count of frames with frame_ok=0; saturates at 16'hFFFF.

Behaviour:
- Reset: the FSM goes to IDLE. All outputs read 0: pl_*, frame_done, frame_ok, err_code, good_cnt, bad_cnt. The CRC register loads CRC_INIT. Reset mid-frame discards the frame and produces no verdict.
- FSM states: IDLE, LEN, PAYLOAD, CRC_H, CRC_L. Only cycles with rx_valid=1 advance the FSM.
- IDLE:
  - A byte equal to SOF_BYTE moves the FSM to LEN and loads CRC_INIT.
  - Any other byte is silently dropped; no counter changes.
- LEN:
  - LEN=0 or LEN>MAX_LEN gives verdict err_code=2 and returns to IDLE.
  - Otherwise the length is latched, the remaining-byte counter is set to LEN, and the FSM moves to PAYLOAD.
- PAYLOAD:
  - Each byte updates the CRC and is forwarded.
  - The counter decrements; the FSM moves to CRC_H when the last byte is accepted.
  - SOF_BYTE inside the payload is ordinary data, because framing is length-delimited.
- CRC_H: the byte is latched as the received CRC high byte.
- CRC_L:
  - The byte is the received CRC low byte.
  - The received CRC is compared with the running CRC; match gives frame_ok=1, err_code=0, otherwise frame_ok=0, err_code=1.
  - The FSM returns to IDLE.
- CRC algorithm (MSB-first, no reflection, no final XOR):
  - Per byte, XOR the data into crc[15:8].
  - Then run 8 iterations: shift left 1, and XOR CRC_POLY if the bit shifted out was 1.
  - With default parameters this is CRC-16/XMODEM.
  - The CRC covers payload bytes only.
- Latency:
  - pl_data/pl_valid are registered and appear the cycle after the accepting rx_valid.
  - frame_done appears the cycle after the CRC_L byte or the offending LEN byte.
  - frame_done, pl_valid, pl_first and pl_last are each high for exactly one cycle.
- Downstream contract: payload is forwarded before the verdict, so the consumer must discard buffered bytes when frame_ok=0. A frame aborted mid-payload produces no pl_last.
- Timeout:
  - The inter-byte counter clears on every accepted byte and increments every cycle while the FSM is not in IDLE.
  - On reaching TIMEOUT_CYCLES-1: verdict err_code=3, return to IDLE.
  - If rx_valid coincides with the timeout cycle, the byte wins: it is processed and the counter clears.
  - In IDLE the counter is held at 0.
- Counters: good_cnt/bad_cnt update in the same cycle frame_done is asserted and saturate, never wrapping.
- Back-to-back frames: a SOF arriving the cycle after CRC_L is accepted; no gap cycle is required.

Decomposition:
- Shared package crc_pkg:
  - FSM state enumeration.
  - Error-code constants ERR_NONE, ERR_CRC, ERR_LEN, ERR_TIMEOUT.
  - Default CRC_POLY and CRC_INIT constants.
  - The crc16 byte-update function, so the CRC checker and any generator use identical arithmetic.
- One sub-module, crc16_byte_update: registered CRC state with clear/enable inputs and the per-byte step. It is reusable by the transmit-side generator.

Test Plan:
- Good frame: 7E 09 "123456789" 31 C3 -> 9 pl_valid pulses (first on '1', last on '9'), then frame_done=1, frame_ok=1, err_code=0, good_cnt=1.
- CRC error: same frame with trailer 31 C4 -> 9 payload pulses, then frame_done=1, frame_ok=0, err_code=1, bad_cnt=1.
- Length bounds:
  - 7E 00 -> err_code=2, no pl_valid.
  - 7E 41 with MAX_LEN=64 -> err_code=2.
  - 7E 01 7E plus its correct CRC -> frame_ok=1 and payload byte 7E forwarded.
- Timeout: 7E 03 AA, then no bytes for TIMEOUT_CYCLES clocks -> err_code=3, FSM in IDLE; a following valid frame passes.
- Noise and back-to-back: 55 00 FF before a good frame -> ignored. Two good frames with zero gap -> two verdicts, good_cnt=2.
- Reset and saturation:
  - reset asserted mid-payload -> no frame_done, counters 0, next frame good.
  - bad_cnt preloaded near 16'hFFFF (force) -> stays at FFFF on further errors.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM states, verdict codes and CRC-16 byte arithmetic.
// Revision 1.0
`default_nettype none

package crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC_H   = 3'd3,
    ST_CRC_L   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [15:0] DEF_CRC_POLY = 16'h1021;
  localparam logic [15:0] DEF_CRC_INIT = 16'h0000;

  // MSB-first, unreflected, no final XOR: one whole byte per call.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  data,
                                               input logic [15:0] poly);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ poly) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_frame_rx_if.sv
// crc_frame_rx_if: UART byte input plus payload/verdict/status outputs of the frame receiver.
// Revision 1.0
`default_nettype none

interface crc_frame_rx_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_first;
  logic        pl_last;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  modport master (
    output rx_data, rx_valid,
    input  pl_data, pl_valid, pl_first, pl_last,
    input  frame_done, frame_ok, err_code, good_cnt, bad_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output pl_data, pl_valid, pl_first, pl_last,
    output frame_done, frame_ok, err_code, good_cnt, bad_cnt
  );
endinterface

`default_nettype wire

// File: rtl/crc16_byte_update.sv
// crc16_byte_update: registered CRC-16 state advanced one byte per enable, shared with the transmit generator.
// Revision 1.0
`default_nettype none

module crc16_byte_update
  import crc_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = DEF_CRC_POLY,
  parameter logic [15:0] CRC_INIT = DEF_CRC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_update(crc, data, CRC_POLY);
    end
  end

endmodule

`default_nettype wire

// File: rtl/crc_frame_rx.sv
// crc_frame_rx: delimits SOF/LEN/payload/CRC frames, forwards payload, issues a CRC verdict per frame.
// Revision 1.0
`default_nettype none

module crc_frame_rx
  import crc_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = 8'h7E,
  parameter int          MAX_LEN        = 64,
  parameter logic [15:0] CRC_POLY       = DEF_CRC_POLY,
  parameter logic [15:0] CRC_INIT       = DEF_CRC_INIT,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input logic           clk,
  input logic           reset,
  crc_frame_rx_if.slave bus
);

  localparam int             TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_t          state;
  logic [7:0]      len;
  logic [7:0]      remain;
  logic [7:0]      crc_hi;
  logic [TO_W-1:0] idle_cnt;
  logic [15:0]     crc_value;
  logic [15:0]     good_cnt;
  logic [15:0]     bad_cnt;
  logic [7:0]      pl_data;
  logic            pl_valid;
  logic            pl_first;
  logic            pl_last;
  logic            frame_done;
  logic            frame_ok;
  logic [1:0]      err_code;

  logic            crc_clear;
  logic            crc_en;
  logic            len_bad;
  logic            verdict;
  logic [1:0]      verdict_err;

  assign crc_clear = bus.rx_valid && (state == ST_IDLE) && (bus.rx_data == SOF_BYTE);
  assign crc_en    = bus.rx_valid && (state == ST_PAYLOAD);
  assign len_bad   = (bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B);

  crc16_byte_update #(
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (bus.rx_data),
    .crc    (crc_value)
  );

  // An arriving byte always takes priority over an expiring timeout.
  always_comb begin
    verdict     = 1'b0;
    verdict_err = ERR_NONE;
    if (bus.rx_valid) begin
      if (state == ST_LEN && len_bad) begin
        verdict     = 1'b1;
        verdict_err = ERR_LEN;
      end else if (state == ST_CRC_L) begin
        verdict     = 1'b1;
        verdict_err = ({crc_hi, bus.rx_data} == crc_value) ? ERR_NONE : ERR_CRC;
      end
    end else if (state != ST_IDLE && idle_cnt == TO_LAST) begin
      verdict     = 1'b1;
      verdict_err = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      remain     <= '0;
      crc_hi     <= '0;
      idle_cnt   <= '0;
      pl_data    <= '0;
      pl_valid   <= 1'b0;
      pl_first   <= 1'b0;
      pl_last    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_NONE;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      pl_valid   <= 1'b0;
      pl_first   <= 1'b0;
      pl_last    <= 1'b0;
      frame_done <= verdict;
      frame_ok   <= verdict && (verdict_err == ERR_NONE);
      err_code   <= verdict_err;

      if (verdict) begin
        if (verdict_err == ERR_NONE) begin
          if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
        end else begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end
      end

      if (state == ST_IDLE || bus.rx_valid || verdict) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (verdict && !bus.rx_valid) begin
        state <= ST_IDLE;
      end

      if (bus.rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == SOF_BYTE) state <= ST_LEN;
          end
          ST_LEN: begin
            if (len_bad) begin
              state <= ST_IDLE;
            end else begin
              len    <= bus.rx_data;
              remain <= bus.rx_data;
              state  <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            pl_data  <= bus.rx_data;
            pl_valid <= 1'b1;
            pl_first <= (remain == len);
            pl_last  <= (remain == 8'd1);
            remain   <= remain - 8'd1;
            if (remain == 8'd1) state <= ST_CRC_H;
          end
          ST_CRC_H: begin
            crc_hi <= bus.rx_data;
            state  <= ST_CRC_L;
          end
          ST_CRC_L: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pl_data    = pl_data;
  assign bus.pl_valid   = pl_valid;
  assign bus.pl_first   = pl_first;
  assign bus.pl_last    = pl_last;
  assign bus.frame_done = frame_done;
  assign bus.frame_ok   = frame_ok;
  assign bus.err_code   = err_code;
  assign bus.good_cnt   = good_cnt;
  assign bus.bad_cnt    = bad_cnt;

endmodule

`default_nettype wire

// File: tb/tb_crc_frame_rx.sv
// tb_crc_frame_rx: table-driven frames with a payload/verdict scoreboard plus timeout, reset and saturation sequences.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_crc_frame_rx;

  localparam int MAX_LEN = 64;
  localparam int TO      = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crc_frame_rx_if bus();

  crc_frame_rx #(
    .SOF_BYTE       (8'h7E),
    .MAX_LEN        (MAX_LEN),
    .CRC_POLY       (16'h1021),
    .CRC_INIT       (16'h0000),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]       len;
    int               npl;
    logic [63:0][7:0] pl;
    logic [15:0]      crc;
    logic [1:0]       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } pl_exp_t;

  typedef struct {
    logic        ok;
    logic [1:0]  err;
    logic [15:0] good;
    logic [15:0] bad;
  } v_exp_t;

  pl_exp_t     exp_pl[$];
  v_exp_t      exp_v[$];
  pl_exp_t     pe;
  v_exp_t      ve;
  vec_t        tbl[8];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] good_m = '0;
  logic [15:0] bad_m  = '0;
  bit          in_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC (feedback = crc MSB xor data bit).
  function automatic logic [15:0] ref_crc(input vec_t v);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < v.npl; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ v.pl[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!in_reset) begin
      if (bus.pl_valid) begin
        if (exp_pl.size() == 0) begin
          check("pl_unexpected", 32'd1, 32'd0);
        end else begin
          pe = exp_pl.pop_front();
          check("pl_data", {24'd0, bus.pl_data}, {24'd0, pe.data});
          check("pl_first", {31'd0, bus.pl_first}, {31'd0, pe.first});
          check("pl_last", {31'd0, bus.pl_last}, {31'd0, pe.last});
        end
      end
      if (bus.frame_done) begin
        if (exp_v.size() == 0) begin
          check("verdict_unexpected", 32'd1, 32'd0);
        end else begin
          ve = exp_v.pop_front();
          check("frame_ok", {31'd0, bus.frame_ok}, {31'd0, ve.ok});
          check("err_code", {30'd0, bus.err_code}, {30'd0, ve.err});
          check("good_cnt", {16'd0, bus.good_cnt}, {16'd0, ve.good});
          check("bad_cnt", {16'd0, bus.bad_cnt}, {16'd0, ve.bad});
        end
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic push_verdict(input logic [1:0] err);
    v_exp_t v;
    if (err == 2'd0) begin
      if (good_m != 16'hFFFF) good_m = good_m + 16'd1;
    end else begin
      if (bad_m != 16'hFFFF) bad_m = bad_m + 16'd1;
    end
    v.ok   = (err == 2'd0);
    v.err  = err;
    v.good = good_m;
    v.bad  = bad_m;
    exp_v.push_back(v);
  endtask

  task automatic send_frame(input vec_t v);
    drive(8'h7E);
    drive(v.len);
    if (v.exp_err == 2'd2) begin
      push_verdict(2'd2);
    end else begin
      for (int i = 0; i < v.npl; i++) begin
        drive(v.pl[i]);
        exp_pl.push_back('{v.pl[i], (i == 0), (i == v.npl - 1)});
      end
      drive(v.crc[15:8]);
      drive(v.crc[7:0]);
      push_verdict(v.exp_err);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    idle(1);
    while ((exp_pl.size() != 0 || exp_v.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    idle(2);
    check({name, "_drained"}, {31'd0, (exp_pl.size() == 0 && exp_v.size() == 0)}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;

    for (int t = 0; t < 8; t++) tbl[t] = '0;
    // "123456789" with its XMODEM check value, then with a corrupted low byte
    tbl[0].len = 8'd9; tbl[0].npl = 9; tbl[0].crc = 16'h31C3; tbl[0].exp_err = 2'd0;
    for (int i = 0; i < 9; i++) tbl[0].pl[i] = 8'(8'h31 + i);
    tbl[1] = tbl[0]; tbl[1].crc = 16'h31C4; tbl[1].exp_err = 2'd1;
    tbl[2].len = 8'h00; tbl[2].exp_err = 2'd2;
    tbl[3].len = 8'h41; tbl[3].exp_err = 2'd2;
    tbl[4].len = 8'd1; tbl[4].npl = 1; tbl[4].pl[0] = 8'h7E; tbl[4].crc = 16'h9F59; tbl[4].exp_err = 2'd0;
    tbl[5].len = 8'd64; tbl[5].npl = 64; tbl[5].exp_err = 2'd0;
    for (int i = 0; i < 64; i++) tbl[5].pl[i] = 8'(i * 3 + 1);
    tbl[5].crc = ref_crc(tbl[5]);
    tbl[6].len = 8'd3; tbl[6].npl = 3; tbl[6].exp_err = 2'd1;
    tbl[6].pl[0] = 8'hA5; tbl[6].pl[1] = 8'h5A; tbl[6].pl[2] = 8'h7E;
    tbl[6].crc = ref_crc(tbl[6]) ^ 16'h0100;
    tbl[7].len = 8'd2; tbl[7].npl = 2; tbl[7].exp_err = 2'd0;
    tbl[7].pl[0] = 8'($urandom_range(0, 255)); tbl[7].pl[1] = 8'($urandom_range(0, 255));
    tbl[7].crc = ref_crc(tbl[7]);

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    check("rst_pl_valid", {31'd0, bus.pl_valid}, 32'd0);
    check("rst_pl_data", {24'd0, bus.pl_data}, 32'd0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_frame_ok", {31'd0, bus.frame_ok}, 32'd0);
    check("rst_err_code", {30'd0, bus.err_code}, 32'd0);
    check("rst_good_cnt", {16'd0, bus.good_cnt}, 32'd0);
    check("rst_bad_cnt", {16'd0, bus.bad_cnt}, 32'd0);
    reset    = 1'b0;
    in_reset = 1'b0;
    idle(2);

    for (int t = 0; t < 8; t++) begin
      send_frame(tbl[t]);
      wait_drain($sformatf("vec%0d", t));
    end

    // Line noise before a frame, then two frames with no gap.
    drive(8'h55); drive(8'h00); drive(8'hFF);
    send_frame(tbl[0]);
    send_frame(tbl[4]);
    wait_drain("noise_b2b");

    // Inter-byte timeout mid-payload, followed by a clean frame.
    drive(8'h7E); drive(8'h03); drive(8'hAA);
    exp_pl.push_back('{8'hAA, 1'b1, 1'b0});
    push_verdict(2'd3);
    idle(1);
    k = 1;
    while (!bus.frame_done && k < 3 * TO) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", {31'd0, (k >= TO && k <= TO + 1)}, 32'd1);
    wait_drain("timeout");
    send_frame(tbl[0]);
    wait_drain("after_timeout");

    // Reset in the middle of a payload discards the frame silently.
    drive(8'h7E); drive(8'h05); drive(8'h11); drive(8'h22);
    exp_pl.push_back('{8'h11, 1'b1, 1'b0});
    exp_pl.push_back('{8'h22, 1'b0, 1'b0});
    idle(2);
    in_reset = 1'b1;
    reset    = 1'b1;
    idle(2);
    check("midrst_good_cnt", {16'd0, bus.good_cnt}, 32'd0);
    check("midrst_bad_cnt", {16'd0, bus.bad_cnt}, 32'd0);
    check("midrst_queue", {31'd0, (exp_pl.size() == 0)}, 32'd1);
    reset    = 1'b0;
    good_m   = '0;
    bad_m    = '0;
    exp_pl.delete();
    exp_v.delete();
    in_reset = 1'b0;
    idle(3);
    send_frame(tbl[0]);
    wait_drain("after_reset");

    // Saturation of the bad-frame counter.
    @(negedge clk);
    force dut.bad_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.bad_cnt;
    bad_m = 16'hFFFE;
    send_frame(tbl[1]);
    wait_drain("sat1");
    send_frame(tbl[3]);
    wait_drain("sat2");
    check("sat_bad_cnt", {16'd0, bus.bad_cnt}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
